// File: rtl/prio_encoder_sync.sv
// Registered, debounced 8-to-3 priority encoder for active-low request lines (bit 7 highest).
// Latency: code valid DEBOUNCE_CYCLES+2 edges after a stable request; oGS 2 edges after iData.
// Backpressure: a held code stays frozen until iAck; ENC_OVERRUN_EN adds the sticky oOverrun flag.
module prio_encoder_sync #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iData,
  input  logic [1:0] iEna,
  input  logic       iAck,
  output logic [2:0] oData,
  output logic       oValid,
  output logic       oGS
`ifdef ENC_OVERRUN_EN
  ,
  output logic       oOverrun
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  state_t           stateNxt;
  logic [7:0]       smp;
  logic [7:0]       act;
  logic             en;
  logic             req;
  logic [2:0]       code;
  logic [2:0]       cand;
  logic [2:0]       candNxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNxt;
  logic [2:0]       dataNxt;
  logic             validNxt;
`ifdef ENC_OVERRUN_EN
  logic             overrunNxt;
`endif

  // Request decode works on the registered sample so every decision sees one consistent snapshot.
  always_comb begin
    act  = ~smp;
    en   = (iEna == 2'b10);
    req  = en & (|act);
    code = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (act[k]) begin
        code = 3'(k);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    candNxt  = cand;
    cntNxt   = cnt;
    dataNxt  = oData;
    validNxt = oValid;
`ifdef ENC_OVERRUN_EN
    overrunNxt = oOverrun;
`endif
    unique case (state)
      IDLE: begin
        if (req) begin
          candNxt  = code;
          cntNxt   = '0;
          stateNxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!req || (code != cand)) begin
          cntNxt   = '0;
          stateNxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          dataNxt  = cand;
          validNxt = 1'b1;
          stateNxt = HOLD;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (iAck) begin
          validNxt = 1'b0;
          stateNxt = RELEASE;
`ifdef ENC_OVERRUN_EN
          overrunNxt = 1'b0;
`endif
        end
`ifdef ENC_OVERRUN_EN
        else if (req && (code != oData)) begin
          overrunNxt = 1'b1;
        end
`endif
      end
      RELEASE: begin
        // One code per press: wait for the key to be let go before arming again.
        if (!req) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      smp    <= 8'hFF;
      cand   <= 3'd0;
      cnt    <= '0;
      oData  <= 3'd0;
      oValid <= 1'b0;
      oGS    <= 1'b0;
    end else begin
      smp    <= iData;
      cand   <= candNxt;
      cnt    <= cntNxt;
      oData  <= dataNxt;
      oValid <= validNxt;
      oGS    <= req;
    end
  end

`ifdef ENC_OVERRUN_EN
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oOverrun <= 1'b0;
    end else begin
      oOverrun <= overrunNxt;
    end
  end
`endif

endmodule

// File: tb/tb_prio_encoder_sync.sv
// Bench for prio_encoder_sync: run-length reference model compared every cycle, plus directed literals.
module tb_prio_encoder_sync;

  localparam int N = 4;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [7:0] iData;
  logic [1:0] iEna;
  logic       iAck;
  logic [2:0] oData;
  logic       oValid;
  logic       oGS;
`ifdef ENC_OVERRUN_EN
  logic       oOverrun;
`endif

  int total = 0;
  int bad   = 0;

  prio_encoder_sync #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iData   (iData),
    .iEna    (iEna),
    .iAck    (iAck),
    .oData   (oData),
    .oValid  (oValid),
    .oGS     (oGS)
`ifdef ENC_OVERRUN_EN
    ,
    .oOverrun(oOverrun)
`endif
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [7:0] actual, input logic [7:0] expect_v);
    total++;
    if (actual !== expect_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, actual, expect_v, $time);
    end
  endtask

  function automatic int topIdx(input logic [7:0] a);
    for (int k = 7; k >= 0; k--) begin
      if (a[k]) return k;
    end
    return -1;
  endfunction

  // Reference: a request is accepted once the same code has been seen on N+1 consecutive edges
  // (one arming edge plus N stable edges); any break, including a code change, restarts the count.
  logic [7:0] mSmp;
  logic [2:0] mData;
  logic [2:0] mRunCode;
  bit         mValid, mGS, mOvr, mHold, mRel, mReady;
  int         mRun;
  int         c;

  initial mReady = 1'b0;

  always @(posedge iClk) begin
    if (!iRst_n) begin
      mSmp = 8'hFF; mData = 3'd0; mValid = 0; mGS = 0; mOvr = 0;
      mHold = 0; mRel = 0; mRun = 0; mRunCode = 3'd0; mReady = 1;
    end else if (mReady) begin
      c   = (iEna == 2'b10) ? topIdx(~mSmp) : -1;
      mGS = (c >= 0);
      if (mHold) begin
        if (iAck) begin
          mHold = 0; mRel = 1; mValid = 0; mOvr = 0;
        end else if (c >= 0 && c != int'(mData)) begin
          mOvr = 1;
        end
      end else if (mRel) begin
        if (c < 0) begin
          mRel = 0; mRun = 0;
        end
      end else begin
        if (c < 0) mRun = 0;
        else if (mRun == 0) begin
          mRun = 1; mRunCode = 3'(c);
        end else if (c == int'(mRunCode)) mRun++;
        else mRun = 0;
        if (mRun == N + 1) begin
          mValid = 1; mData = mRunCode; mHold = 1; mRun = 0;
        end
      end
      mSmp = iData;
    end
  end

  always @(negedge iClk) begin
    if (mReady) begin
      chk("model_valid", oValid, mValid);
      chk("model_gs", oGS, mGS);
      if (mValid) chk("model_data", oData, mData);
`ifdef ENC_OVERRUN_EN
      chk("model_overrun", oOverrun, mOvr);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic ackOnce();
    iAck = 1'b1;
    tick(1);
    iAck = 1'b0;
    chk("lit_ack_clears", oValid, 1'b0);
  endtask

  initial begin
    iRst_n = 1'b0; iData = 8'h00; iEna = 2'b10; iAck = 1'b0;
    tick(2);
    chk("lit_rst_valid", oValid, 1'b0);
    chk("lit_rst_data", oData, 3'd0);
    chk("lit_rst_gs", oGS, 1'b0);
    iRst_n = 1'b1;
    tick(1); chk("lit_gs_e1", oGS, 1'b0);
    tick(1); chk("lit_gs_e2", oGS, 1'b1);
    tick(3); chk("lit_all_e5", oValid, 1'b0);
    tick(1); chk("lit_all_e6", oValid, 1'b1); chk("lit_all_code7", oData, 3'd7);
    ackOnce();
    tick(8); chk("lit_all_held_once", oValid, 1'b0);

    // Basic: line 3, single code while held, then line 2
    iData = 8'hFF; tick(2);
    iData = 8'hF7;
    tick(1); chk("lit_b_gs_e1", oGS, 1'b0);
    tick(1); chk("lit_b_gs_e2", oGS, 1'b1);
    tick(3); chk("lit_b_e5", oValid, 1'b0);
    tick(1); chk("lit_b_e6", oValid, 1'b1); chk("lit_b_code3", oData, 3'd3);
    ackOnce();
    tick(10); chk("lit_b_no_repeat", oValid, 1'b0);
    iData = 8'hFF; tick(2);
    iData = 8'hFB; tick(6);
    chk("lit_b2_valid", oValid, 1'b1); chk("lit_b2_code2", oData, 3'd2);
    ackOnce();
    iData = 8'hFF; tick(2);

    // Bounce on line 5
    for (int i = 0; i < 5; i++) begin
      iData = 8'hDF; tick(2);
      iData = 8'hFF; tick(2);
    end
    chk("lit_bounce_none", oValid, 1'b0);
    iData = 8'hDF;
    tick(5); chk("lit_bounce_e5", oValid, 1'b0);
    tick(1); chk("lit_bounce_e6", oValid, 1'b1); chk("lit_bounce_code5", oData, 3'd5);
    ackOnce();
    iData = 8'hFF; tick(2);

    // Line 6 preempts line 0 mid-debounce
    iData = 8'hFE; tick(3);
    iData = 8'hBE;
    tick(6); chk("lit_prio_early", oValid, 1'b0);
    tick(1); chk("lit_prio_valid", oValid, 1'b1); chk("lit_prio_code6", oData, 3'd6);
    ackOnce();
    iData = 8'hFF; tick(2);

    // Disabled encoding
    iEna = 2'b11; iData = 8'h00; tick(10);
    chk("lit_dis_valid", oValid, 1'b0); chk("lit_dis_gs", oGS, 1'b0);
    iEna = 2'b10; iData = 8'hFF; tick(2);

    // Hold frozen while another line is requested
    iData = 8'hEF; tick(6);
    chk("lit_hold_valid", oValid, 1'b1); chk("lit_hold_code4", oData, 3'd4);
    iData = 8'hFD;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("lit_hold_frozen_v", oValid, 1'b1);
      chk("lit_hold_frozen_d", oData, 3'd4);
    end
`ifdef ENC_OVERRUN_EN
    chk("lit_overrun_set", oOverrun, 1'b1);
`endif
    ackOnce();
`ifdef ENC_OVERRUN_EN
    chk("lit_overrun_clr", oOverrun, 1'b0);
`endif
    iData = 8'hFF; tick(2);

    // Reset while holding code 6
    iData = 8'hBF; tick(6);
    chk("lit_mr_valid", oValid, 1'b1); chk("lit_mr_code6", oData, 3'd6);
    iRst_n = 1'b0; tick(1); iRst_n = 1'b1;
    chk("lit_mr_rst_valid", oValid, 1'b0); chk("lit_mr_rst_data", oData, 3'd0);
    tick(5); chk("lit_mr_e5", oValid, 1'b0);
    tick(1); chk("lit_mr_e6", oValid, 1'b1); chk("lit_mr_code6b", oData, 3'd6);
    ackOnce();
    iData = 8'hFF; tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
